// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 definitions for the schedule and compression blocks.
//   - word type and the 8-word register-file type (element 7 = a / H0,
//     element 0 = h / H7, so a 256-bit chaining value maps onto it directly)
//   - compression FSM state encoding
//   - round-constant table K[0..63] and the initial hash value IV
//   - BSIG0/BSIG1/CH/MAJ (compression) and SSIG0/SSIG1 (message schedule)
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [7:0][WORD_W-1:0]  regs_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam regs_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   state_i : working registers, [7]=a ... [0]=h
//   k_i     : round constant K[t]
//   w_i     : schedule word W[t]
//   state_o : working registers after the round, same ordering
module sha256_round
    import sha256_pkg::*;
(
    input  regs_t state_i,
    input  word_t k_i,
    input  word_t w_i,
    output regs_t state_o
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_i;

    assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
    assign t2 = bsig0(a) + maj(a, b, c);

    // Every register shifts down one slot; only a and e take new values.
    assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: consumer of the SHA-256 message-schedule stream.
// Accepts W[0..ROUNDS-1] one word per w_valid/w_ready handshake, runs one
// compression round per accepted word, then adds the chaining value and
// presents the digest with a one-cycle done pulse.
//   clk, reset     : clock; asynchronous active-high reset
//   start, h_in    : begin a block with chaining value h_in (H0 in [255:224])
//   w_valid, w_in  : schedule word stream, in order t = 0..ROUNDS-1
//   w_ready        : high while a word can be accepted (ROUND state)
//   busy           : high from accepted start until the done cycle
//   done           : one-cycle pulse, digest_out valid
//   digest_out     : H'0 in [255:224] ... H'7 in [31:0], held until next done
// ROUNDS must be in 1..64; values below 64 are for debug benches only.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [31:0]  w_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest_out
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    state_e     state_q, state_d;
    logic [6:0] t_q, t_d;
    regs_t      work_q, work_d;    // a..h
    regs_t      hold_q, hold_d;    // chaining value for the feed-forward
    regs_t      digest_q, digest_d;
    logic       done_q, done_d;
    regs_t      round_out;

    sha256_round u_round (
        .state_i (work_q),
        .k_i     (K[t_q[5:0]]),
        .w_i     (w_in),
        .state_o (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            work_q   <= '0;
            hold_q   <= '0;
            digest_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            t_q      <= t_d;
            work_q   <= work_d;
            hold_q   <= hold_d;
            digest_q <= digest_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latches.
        state_d  = state_q;
        t_d      = t_q;
        work_d   = work_q;
        hold_d   = hold_q;
        digest_d = digest_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The done cycle is spent in IDLE, so back-to-back starts land here.
                if (start) begin
                    hold_d  = h_in;
                    work_d  = h_in;
                    t_d     = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_valid && w_ready) begin
                    work_d = round_out;
                    t_d    = t_q + 7'd1;
                    if (t_q == LAST_T) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    digest_d[i] = hold_q[i] + work_q[i];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_ready    = (state_q == ST_ROUND);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign digest_out = digest_q;

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: known-answer and model-based checks for sha256_compress.
// Expected digests are pushed to a scoreboard when a block starts and popped
// when done pulses; multi-cycle corner cases are driven as explicit sequences.
module tb_sha256_compress;
    import sha256_pkg::K;

    localparam int ROUNDS = 64;

    typedef logic [15:0][31:0] blk_t;    // message block, index = word number
    typedef logic [63:0][31:0] sched_t;  // W[0..63], index = t

    typedef struct {
        logic [255:0] h;
        blk_t         m;
        logic [255:0] exp;
        int           duty;
    } vec_t;

    localparam logic [255:0] TB_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] h_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_in;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int done_cyc;
    int start_cyc;
    int exp_dones;
    logic prev_done;
    logic [255:0] sb[$];

    sha256_compress #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .h_in       (h_in),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_in       (w_in),
        .busy       (busy),
        .done       (done),
        .digest_out (digest_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t expand(input blk_t m);
        sched_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = m[t];
            end else begin
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
        end
        return w;
    endfunction

    function automatic logic [255:0] model(input logic [255:0] hin, input sched_t w);
        logic [31:0] v [8];   // v[0]=a ... v[7]=h
        logic [31:0] t1, t2;
        logic [255:0] out;
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < ROUNDS; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) out[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return out;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected digest.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (prev_done) fail_now("done_not_single_pulse");
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                check("digest", digest_out, sb.pop_front());
            end
            done_cnt++;
            done_cyc = cyc;
        end
        prev_done = done;
    end

    // ---------------- stimulus ----------------
    task automatic start_block(input logic [255:0] h, input logic [255:0] exp);
        start = 1'b1;
        h_in  = h;
        sb.push_back(exp);
        @(posedge clk); #1;
        start     = 1'b0;
        h_in      = ~h;   // must not matter once the block has started
        start_cyc = cyc;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed(input sched_t w, input int duty, input int glitch_at, input int abort_at);
        int   i = 0;
        int   n = 0;
        logic glitched = 1'b0;
        logic acc;
        while (i < ROUNDS && n < 2000) begin
            if (i == abort_at) begin
                w_valid = 1'b0;
                reset   = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_w_ready", w_ready, 0);
                check("abort_done", done, 0);
                check("abort_digest", digest_out, 0);
                sb.delete();
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            w_in    = w[i];
            w_valid = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            if (i == glitch_at && !glitched) begin
                start    = 1'b1;
                h_in     = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
                glitched = 1'b1;
            end else begin
                start = 1'b0;
            end
            acc = w_valid && w_ready;
            @(posedge clk); #1;
            if (start) check("busy_after_glitch_start", busy, 1);
            if (acc) i++;
            n++;
        end
        start   = 1'b0;
        w_valid = 1'b0;
        if (i < ROUNDS) fail_now("feed_timeout");
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) fail_now("done_timeout");
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [4];
    blk_t abc_m, empty_m, rnd_m;
    logic [255:0] rnd_h;

    initial begin
        checks = 0; errors = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
        start_cyc = 0; exp_dones = 0; prev_done = 1'b0;
        reset = 1'b1; start = 1'b0; h_in = '0; w_valid = 1'b0; w_in = '0;

        abc_m     = '0;
        abc_m[0]  = 32'h61626380;
        abc_m[15] = 32'h00000018;
        empty_m    = '0;
        empty_m[0] = 32'h80000000;
        for (int j = 0; j < 16; j++) rnd_m[j] = $urandom;
        for (int j = 0; j < 8; j++) rnd_h[32*j +: 32] = $urandom;

        vecs[0] = '{h: TB_IV, m: abc_m,   exp: ABC_DIGEST,   duty: 100};
        vecs[1] = '{h: TB_IV, m: empty_m, exp: EMPTY_DIGEST, duty: 100};
        vecs[2] = '{h: rnd_h, m: rnd_m,   exp: model(rnd_h, expand(rnd_m)), duty: 100};
        vecs[3] = '{h: TB_IV, m: abc_m,   exp: ABC_DIGEST,   duty: 50};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_w_ready", w_ready, 0);
        check("reset_done", done, 0);
        check("reset_digest", digest_out, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven blocks.
        for (int v = 0; v < 4; v++) begin
            start_block(vecs[v].h, vecs[v].exp);
            feed(expand(vecs[v].m), vecs[v].duty, -1, -1);
            exp_dones++;
            wait_done(exp_dones);
            // Start edge to the edge that raises done: 64 rounds + FINAL.
            if (v == 0) check("latency_edges", done_cyc - start_cyc, ROUNDS + 1);
            repeat (3) @(posedge clk);
            #1;
            check("digest_hold", digest_out, vecs[v].exp);
        end

        // start mid-block is ignored; a start in the done cycle begins the next block.
        start_block(TB_IV, ABC_DIGEST);
        feed(expand(abc_m), 100, 20, -1);
        exp_dones++;
        @(posedge clk); #1;
        check("done_cycle", done, 1);
        start_block(TB_IV, EMPTY_DIGEST);
        check("b2b_w_ready", w_ready, 1);
        feed(expand(empty_m), 100, -1, -1);
        exp_dones++;
        wait_done(exp_dones);

        // Reset in the middle of a block: no done, outputs cleared.
        @(posedge clk); #1;
        start_block(TB_IV, ABC_DIGEST);
        feed(expand(abc_m), 100, -1, 30);
        repeat (80) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt, exp_dones);
        check("digest_after_abort", digest_out, 0);
        start_block(TB_IV, ABC_DIGEST);
        feed(expand(abc_m), 100, -1, -1);
        exp_dones++;
        wait_done(exp_dones);

        // w_valid asserted in IDLE must not consume words.
        @(posedge clk); #1;
        w_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            w_in = $urandom;
            @(posedge clk); #1;
        end
        check("idle_w_ready", w_ready, 0);
        start_block(TB_IV, ABC_DIGEST);
        feed(expand(abc_m), 100, -1, -1);
        exp_dones++;
        wait_done(exp_dones);

        repeat (5) @(posedge clk);
        #1;
        check("total_dones", done_cnt, exp_dones);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
